round_key_sched: RTL and testbench



---
 rtl/round_key_sched_pkg.sv | 27 ++
 rtl/key_gen.sv | 29 ++
 rtl/round_key_sched.sv | 111 +++++++++++
 tb/tb_round_key_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/round_key_sched_pkg.sv
// rtl/round_key_sched_pkg.sv - shared constants, state enum and key word helper
// Purpose: widths and FSM state type shared by round_key_sched and key_gen,
//          plus the key word function kw(n).
// Ports:   none (package).
package round_key_sched_pkg;

  localparam int KEY_W  = 144;
  localparam int WORD_W = 9;
  localparam int IDX_W  = 7;
  localparam int NWORDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // kw(n): word p of the key, where p = (16 - (n mod 16)) mod 16, XORed with n.
  // The 4-bit negation of n[3:0] gives exactly that wrapped word pointer.
  function automatic logic [WORD_W-1:0] key_word(input logic [KEY_W-1:0] key,
                                                 input logic [IDX_W-1:0] n);
    logic [3:0] p;
    p = 4'd0 - n[3:0];
    return key[WORD_W*p +: WORD_W] ^ {2'b00, n};
  endfunction

endpackage

// File: rtl/key_gen.sv
// rtl/key_gen.sv - combinational round-key generator for rounds i-1, i, i+1
// Purpose: derives the three neighbouring round keys from the master key.
// Ports:   key    in  144  master key, word w = key[9w+8:9w]
//          iII    in  7    round index i
//          keyI   out 9    kw(i-1)
//          keyII  out 9    kw(i)
//          keyIII out 9    kw(i+1)
module key_gen
  import round_key_sched_pkg::*;
(
  input  logic [KEY_W-1:0]  key,
  input  logic [IDX_W-1:0]  iII,
  output logic [WORD_W-1:0] keyI,
  output logic [WORD_W-1:0] keyII,
  output logic [WORD_W-1:0] keyIII
);

  logic [IDX_W-1:0] idx_prev;
  logic [IDX_W-1:0] idx_next;

  // 7-bit arithmetic: 0-1 wraps to 127 and 127+1 wraps to 0.
  assign idx_prev = iII - 7'd1;
  assign idx_next = iII + 7'd1;

  assign keyI   = key_word(key, idx_prev);
  assign keyII  = key_word(key, iII);
  assign keyIII = key_word(key, idx_next);

endmodule

// File: rtl/round_key_sched.sv
// rtl/round_key_sched.sv - round-key sequencer driving the round datapath
// Purpose: latches master key and round count on start, steps round index
//          1..num_rounds and presents kw(i-1), kw(i), kw(i+1) over valid/ready.
// Ports:   clk, rst (async, active-high)
//          start, abort                 control requests
//          key_in[143:0], num_rounds[6:0] captured on accepted start
//          busy, done                   status (done is a one-cycle pulse)
//          rk_valid / rk_ready          round-key handshake
//          rk_round, rk_prev, rk_cur, rk_next   round index and its three keys
module round_key_sched
  import round_key_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [IDX_W-1:0]  num_rounds,
  output logic              busy,
  output logic              done,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [IDX_W-1:0]  rk_round,
  output logic [WORD_W-1:0] rk_prev,
  output logic [WORD_W-1:0] rk_cur,
  output logic [WORD_W-1:0] rk_next
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [IDX_W-1:0]  nr_q, nr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      nr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      nr_q    <= nr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    nr_d     = nr_q;
    busy     = 1'b0;
    done     = 1'b0;
    rk_valid = 1'b0;

    case (state_q)
      RUN: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase

    // Abort outranks both a new start and a handshake in flight.
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            key_d   = key_in;
            nr_d    = num_rounds;
            cnt_d   = 7'd1;
            state_d = (num_rounds == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rk_ready) begin
            if (cnt_q == nr_q) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign rk_round = cnt_q;

  key_gen u_key_gen (
    .key    (key_q),
    .iII    (cnt_q),
    .keyI   (rk_prev),
    .keyII  (rk_cur),
    .keyIII (rk_next)
  );

endmodule

// File: tb/tb_round_key_sched.sv
// tb/tb_round_key_sched.sv - directed vector bench for round_key_sched
module tb_round_key_sched;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [143:0] key_in;
  logic [6:0]   num_rounds;
  logic         busy;
  logic         done;
  logic         rk_valid;
  logic         rk_ready;
  logic [6:0]   rk_round;
  logic [8:0]   rk_prev;
  logic [8:0]   rk_cur;
  logic [8:0]   rk_next;

  int n_checks;
  int n_fail;

  round_key_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .key_in     (key_in),
    .num_rounds (num_rounds),
    .busy       (busy),
    .done       (done),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_round   (rk_round),
    .rk_prev    (rk_prev),
    .rk_cur     (rk_cur),
    .rk_next    (rk_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    string        name;
    logic [143:0] key;
    logic [6:0]   nr;
    logic [6:0]   round;
    logic [8:0]   exp_prev;
    logic [8:0]   exp_cur;
    logic [8:0]   exp_next;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_sched(input logic [143:0] k, input logic [6:0] n);
    key_in     = k;
    num_rounds = n;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic chk_bundle(input string nm, input logic [6:0] r,
                            input logic [8:0] p, input logic [8:0] c, input logic [8:0] x);
    chk({nm, "_valid"}, rk_valid, 1);
    chk({nm, "_round"}, rk_round, r);
    chk({nm, "_prev"},  rk_prev, p);
    chk({nm, "_cur"},   rk_cur, c);
    chk({nm, "_next"},  rk_next, x);
  endtask

  logic [143:0] key_w;
  logic [143:0] key_wrap;
  logic         found;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    key_in     = '0;
    num_rounds = '0;
    rk_ready   = 1'b0;

    for (int w = 0; w < 16; w++) key_w[9*w +: 9] = 9'(w);
    key_wrap        = '0;
    key_wrap[8:0]   = 9'h1A5;

    vecs[0] = '{"basic_r1",  144'd0, 7'd3,   7'd1,   9'd0,   9'd1,   9'd2};
    vecs[1] = '{"basic_r2",  144'd0, 7'd3,   7'd2,   9'd1,   9'd2,   9'd3};
    vecs[2] = '{"basic_r3",  144'd0, 7'd3,   7'd3,   9'd2,   9'd3,   9'd4};
    vecs[3] = '{"words_r1",  key_w,  7'd16,  7'd1,   9'd0,   9'd14,  9'd12};
    vecs[4] = '{"words_r5",  key_w,  7'd16,  7'd5,   9'd8,   9'd14,  9'd12};
    vecs[5] = '{"words_r16", key_w,  7'd16,  7'd16,  9'd14,  9'd16,  9'd30};
    vecs[6] = '{"wrap_r127", key_wrap, 7'd127, 7'd127, 9'h07E, 9'h07F, 9'h1A5};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_valid", rk_valid, 0);
    chk("rst_round", rk_round, 0);
    chk("rst_prev",  rk_prev, 127);
    chk("rst_cur",   rk_cur, 0);
    chk("rst_next",  rk_next, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Table vectors: step with ready pulses until the target round shows.
    foreach (vecs[i]) begin
      rk_ready = 1'b0;
      start_sched(vecs[i].key, vecs[i].nr);
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
        if (rk_valid && rk_round == vecs[i].round) begin
          found = 1'b1;
        end else begin
          rk_ready = 1'b1;
          @(negedge clk);
          rk_ready = 1'b0;
        end
      end
      chk({vecs[i].name, "_reached"}, found, 1);
      if (found) chk_bundle(vecs[i].name, vecs[i].round,
                            vecs[i].exp_prev, vecs[i].exp_cur, vecs[i].exp_next);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk({vecs[i].name, "_abort_idle"}, busy, 0);
    end

    // Back-to-back rounds and done timing
    rk_ready = 1'b1;
    start_sched('0, 7'd3);
    chk_bundle("seq_r1", 7'd1, 9'd0, 9'd1, 9'd2);
    @(negedge clk);
    chk_bundle("seq_r2", 7'd2, 9'd1, 9'd2, 9'd3);
    @(negedge clk);
    chk_bundle("seq_r3", 7'd3, 9'd2, 9'd3, 9'd4);
    @(negedge clk);
    chk("seq_done",       done, 1);
    chk("seq_done_valid", rk_valid, 0);
    chk("seq_done_busy",  busy, 1);
    @(negedge clk);
    chk("seq_after_done", done, 0);
    chk("seq_after_busy", busy, 0);

    // Backpressure at round 2, with ignored start and input changes
    rk_ready = 1'b0;
    start_sched('0, 7'd3);
    rk_ready = 1'b1;
    @(negedge clk);
    chk("bp_round2", rk_round, 2);
    rk_ready   = 1'b0;
    key_in     = '1;
    num_rounds = 7'd1;
    start      = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_bundle("bp_hold", 7'd2, 9'd1, 9'd2, 9'd3);
    end
    start    = 1'b0;
    rk_ready = 1'b1;
    @(negedge clk);
    chk_bundle("bp_r3", 7'd3, 9'd2, 9'd3, 9'd4);
    @(negedge clk);
    chk("bp_done", done, 1);
    @(negedge clk);
    chk("bp_idle", busy, 0);

    // Zero rounds
    rk_ready = 1'b1;
    start_sched('0, 7'd0);
    chk("zero_done",  done, 1);
    chk("zero_valid", rk_valid, 0);
    chk("zero_busy",  busy, 1);
    @(negedge clk);
    chk("zero_idle_busy", busy, 0);
    chk("zero_idle_done", done, 0);

    // Abort at round 2 beats the handshake; no done follows
    rk_ready = 1'b1;
    start_sched('0, 7'd5);
    chk("ab_r1", rk_round, 1);
    @(negedge clk);
    chk("ab_r2", rk_round, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy",  busy, 0);
    chk("ab_valid", rk_valid, 0);
    chk("ab_done",  done, 0);
    @(negedge clk);
    chk("ab_no_done_later", done, 0);

    // Asynchronous reset between edges
    rk_ready = 1'b1;
    start_sched(key_w, 7'd16);
    @(negedge clk);
    chk("rr_r2", rk_round, 2);
    rk_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rr_valid", rk_valid, 0);
    chk("rr_busy",  busy, 0);
    chk("rr_round", rk_round, 0);
    chk("rr_cur",   rk_cur, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    start_sched(key_w, 7'd16);
    chk_bundle("rr_restart", 7'd1, 9'd0, 9'd14, 9'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
